// File: rtl/phy_regfile_if.sv
// Port bundle of the physical register file: two read groups, writeback,
// commit-side invalidation, flush invalidation and valid-bit restore.
interface phy_regfile_if #(
  parameter int PHY_REG_NUM      = 64,
  parameter int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM),
  parameter int REG_DATA_WIDTH   = 32,
  parameter int READREG_WIDTH    = 2,
  parameter int WB_WIDTH         = 4,
  parameter int COMMIT_WIDTH     = 4
);
  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] readreg_phyf_id;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   phyf_readreg_data;
  logic [READREG_WIDTH-1:0][1:0]                       phyf_readreg_data_valid;

  logic [READREG_WIDTH-1:0][1:0][PHY_REG_ID_WIDTH-1:0] issue_phyf_id;
  logic [READREG_WIDTH-1:0][1:0][REG_DATA_WIDTH-1:0]   phyf_issue_data;
  logic [READREG_WIDTH-1:0][1:0]                       phyf_issue_data_valid;

  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]           wb_phyf_id;
  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]             wb_phyf_data;
  logic [WB_WIDTH-1:0]                                 wb_phyf_we;

  logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]       commit_phyf_id;
  logic [COMMIT_WIDTH-1:0]                             commit_phyf_invalid;
  logic [PHY_REG_ID_WIDTH-1:0]                         commit_phyf_flush_id;
  logic                                                commit_phyf_flush_invalid;
  logic [PHY_REG_NUM-1:0]                              commit_phyf_data_valid;
  logic                                                commit_phyf_data_valid_restore;

  modport master (
    output readreg_phyf_id, issue_phyf_id,
    output wb_phyf_id, wb_phyf_data, wb_phyf_we,
    output commit_phyf_id, commit_phyf_invalid,
    output commit_phyf_flush_id, commit_phyf_flush_invalid,
    output commit_phyf_data_valid, commit_phyf_data_valid_restore,
    input  phyf_readreg_data, phyf_readreg_data_valid,
    input  phyf_issue_data, phyf_issue_data_valid
  );

  modport slave (
    input  readreg_phyf_id, issue_phyf_id,
    input  wb_phyf_id, wb_phyf_data, wb_phyf_we,
    input  commit_phyf_id, commit_phyf_invalid,
    input  commit_phyf_flush_id, commit_phyf_flush_invalid,
    input  commit_phyf_data_valid, commit_phyf_data_valid_restore,
    output phyf_readreg_data, phyf_readreg_data_valid,
    output phyf_issue_data, phyf_issue_data_valid
  );
endinterface

// File: rtl/phy_regfile.sv
// Physical register file: data words plus ready bits, combinational reads,
// writeback, then commit/flush invalidation, then bulk valid restore.
module phy_regfile #(
  parameter int PHY_REG_NUM      = 64,
  parameter int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM),
  parameter int ARCH_REG_NUM     = 32,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int READREG_WIDTH    = 2,
  parameter int WB_WIDTH         = 4,
  parameter int COMMIT_WIDTH     = 4
) (
  input  logic          clk,
  input  logic          rst,
  phy_regfile_if.slave  bus
);
  typedef logic [PHY_REG_ID_WIDTH-1:0] id_t;

  logic [REG_DATA_WIDTH-1:0] data_q [PHY_REG_NUM];
  logic [REG_DATA_WIDTH-1:0] data_d [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0]    valid_q;
  logic [PHY_REG_NUM-1:0]    valid_d;

  // Reads see only registered state; no same-cycle writeback bypass.
  always_comb begin
    bus.phyf_readreg_data       = '0;
    bus.phyf_readreg_data_valid = '0;
    bus.phyf_issue_data         = '0;
    bus.phyf_issue_data_valid   = '0;
    for (int i = 0; i < READREG_WIDTH; i++) begin
      for (int j = 0; j < 2; j++) begin
        bus.phyf_readreg_data[i][j]       = data_q[bus.readreg_phyf_id[i][j]];
        bus.phyf_readreg_data_valid[i][j] = valid_q[bus.readreg_phyf_id[i][j]];
        bus.phyf_issue_data[i][j]         = data_q[bus.issue_phyf_id[i][j]];
        bus.phyf_issue_data_valid[i][j]   = valid_q[bus.issue_phyf_id[i][j]];
      end
    end
  end

  // Later steps override earlier ones; ascending port order lets the highest port win.
  always_comb begin
    id_t wid;
    data_d  = data_q;
    valid_d = valid_q;
    wid     = '0;
    for (int p = 0; p < WB_WIDTH; p++) begin
      if (bus.wb_phyf_we[p]) begin
        wid          = bus.wb_phyf_id[p];
        data_d[wid]  = bus.wb_phyf_data[p];
        valid_d[wid] = 1'b1;
      end
    end
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (bus.commit_phyf_invalid[c]) begin
        valid_d[bus.commit_phyf_id[c]] = 1'b0;
      end
    end
    if (bus.commit_phyf_flush_invalid) begin
      valid_d[bus.commit_phyf_flush_id] = 1'b0;
    end
    if (bus.commit_phyf_data_valid_restore) begin
      valid_d = bus.commit_phyf_data_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= (i >= 1) && (i < ARCH_REG_NUM);
      end
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_phy_regfile.sv
// Bench for phy_regfile: directed vector table, hand-written corner sequences
// and randomized traffic against an array-based reference model.
module tb_phy_regfile;
  localparam int N = 64, IDW = 6, ARCH = 32, DW = 32, RW = 2, WBW = 4, CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phy_regfile_if #(.PHY_REG_NUM(N), .PHY_REG_ID_WIDTH(IDW), .REG_DATA_WIDTH(DW),
                   .READREG_WIDTH(RW), .WB_WIDTH(WBW), .COMMIT_WIDTH(CW)) bus ();

  phy_regfile #(.PHY_REG_NUM(N), .PHY_REG_ID_WIDTH(IDW), .ARCH_REG_NUM(ARCH),
                .REG_DATA_WIDTH(DW), .READREG_WIDTH(RW), .WB_WIDTH(WBW),
                .COMMIT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [WBW-1:0]          we;
    logic [WBW-1:0][IDW-1:0] wid;
    logic [WBW-1:0][DW-1:0]  wdata;
    logic [CW-1:0]           cinv;
    logic [CW-1:0][IDW-1:0]  cid;
    logic                    fl;
    logic [IDW-1:0]          fid;
    logic                    rs;
    logic [N-1:0]            img;
    logic [IDW-1:0]          chk_id;
    logic                    exp_valid;
    logic [DW-1:0]           exp_data;
  } stim_t;

  stim_t vecs[$];
  logic [DW-1:0] m_data [N];
  logic          m_valid [N];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i]  = '0;
      m_valid[i] = (i >= 1 && i < ARCH);
    end
  endtask

  task automatic model_step(input stim_t v);
    for (int p = 0; p < WBW; p++)
      if (v.we[p]) begin
        m_data[v.wid[p]]  = v.wdata[p];
        m_valid[v.wid[p]] = 1'b1;
      end
    for (int c = 0; c < CW; c++)
      if (v.cinv[c]) m_valid[v.cid[c]] = 1'b0;
    if (v.fl) m_valid[v.fid] = 1'b0;
    if (v.rs)
      for (int i = 0; i < N; i++) m_valid[i] = v.img[i];
  endtask

  task automatic drive(input stim_t v);
    bus.wb_phyf_we                     = v.we;
    bus.wb_phyf_id                     = v.wid;
    bus.wb_phyf_data                   = v.wdata;
    bus.commit_phyf_invalid            = v.cinv;
    bus.commit_phyf_id                 = v.cid;
    bus.commit_phyf_flush_invalid      = v.fl;
    bus.commit_phyf_flush_id           = v.fid;
    bus.commit_phyf_data_valid_restore = v.rs;
    bus.commit_phyf_data_valid         = v.img;
  endtask

  task automatic set_id(input int k, input logic [IDW-1:0] id);
    if (k < 4) bus.readreg_phyf_id[k/2][k%2] = id;
    else       bus.issue_phyf_id[(k-4)/2][k%2] = id;
  endtask

  function automatic logic rd_valid(input int k);
    if (k < 4) return bus.phyf_readreg_data_valid[k/2][k%2];
    return bus.phyf_issue_data_valid[(k-4)/2][k%2];
  endfunction

  function automatic logic [DW-1:0] rd_data(input int k);
    if (k < 4) return bus.phyf_readreg_data[k/2][k%2];
    return bus.phyf_issue_data[(k-4)/2][k%2];
  endfunction

  task automatic check_all(input string name);
    for (int id = 0; id < N; id++) begin
      set_id(0, IDW'(id));
      set_id(7, IDW'(id));
      #1;
      chk({name, "_rr_valid"}, rd_valid(0), m_valid[id]);
      chk({name, "_rr_data"},  rd_data(0),  m_data[id]);
      chk({name, "_is_valid"}, rd_valid(7), m_valid[id]);
      chk({name, "_is_data"},  rd_data(7),  m_data[id]);
    end
  endtask

  task automatic apply_vec(input stim_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    model_step(v);
    drive('0);
    set_id(2, v.chk_id);
    #1;
    chk("vec_valid", rd_valid(2), v.exp_valid);
    chk("vec_data",  rd_data(2),  v.exp_data);
    check_all("vec_model");
  endtask

  initial begin
    stim_t v;
    rst = 1'b1;
    drive('0);
    bus.readreg_phyf_id = '0;
    bus.issue_phyf_id   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 8; k++) chk("reset_id0_valid", rd_valid(k), 0);

    // Each port swept alone; the others stay on id 0, which is invalid out of reset.
    for (int k = 0; k < 8; k++)
      for (int id = 0; id < N; id++) begin
        bus.readreg_phyf_id = '0;
        bus.issue_phyf_id   = '0;
        set_id(k, IDW'(id));
        #1;
        for (int m = 0; m < 8; m++) begin
          chk("sweep_valid", rd_valid(m), (m == k) ? (id >= 1 && id < ARCH) : 0);
          chk("sweep_data",  rd_data(m),  0);
        end
      end

    for (int p = 0; p < 4; p++) begin
      v = '0; v.we[p] = 1'b1; v.wid[p] = IDW'(p); v.wdata[p] = 32'h1acdef89 + p;
      v.chk_id = IDW'(p); v.exp_valid = 1'b1; v.exp_data = 32'h1acdef89 + p;
      vecs.push_back(v);
    end
    for (int c = 0; c < 4; c++) begin
      v = '0; v.cinv[c] = 1'b1; v.cid[c] = IDW'(c);
      v.chk_id = IDW'(c); v.exp_valid = 1'b0; v.exp_data = 32'h1acdef89 + c;
      vecs.push_back(v);
    end
    v = '0; v.fl = 1'b1; v.fid = 6'd10; v.chk_id = 6'd10; v.exp_valid = 1'b0; vecs.push_back(v);
    v = '0; v.fl = 1'b1; v.fid = 6'd10; v.rs = 1'b1; v.img = '1;
    v.chk_id = 6'd10; v.exp_valid = 1'b1; vecs.push_back(v);
    v = '0; v.fl = 1'b1; v.fid = 6'd10; v.rs = 1'b1; v.img = '0;
    v.chk_id = 6'd10; v.exp_valid = 1'b0; vecs.push_back(v);
    v = '0; v.fl = 1'b1; v.fid = 6'd10; v.rs = 1'b1; v.img = 64'h0000_0000_FFFF_FFFE;
    v.chk_id = 6'd10; v.exp_valid = 1'b1; vecs.push_back(v);
    v = '0; v.we[0] = 1'b1; v.wid[0] = 6'd5; v.wdata[0] = 32'hcafe0005;
    v.cinv[2] = 1'b1; v.cid[2] = 6'd5;
    v.chk_id = 6'd5; v.exp_valid = 1'b0; v.exp_data = 32'hcafe0005; vecs.push_back(v);
    v = '0; v.we[1] = 1'b1; v.wid[1] = 6'd7; v.wdata[1] = 32'h11111111;
    v.we[3] = 1'b1; v.wid[3] = 6'd7; v.wdata[3] = 32'h33333333;
    v.chk_id = 6'd7; v.exp_valid = 1'b1; v.exp_data = 32'h33333333; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // Read during a writeback cycle sees the old word until the edge.
    @(negedge clk);
    v = '0; v.we[2] = 1'b1; v.wid[2] = 6'd20; v.wdata[2] = 32'hdeadbeef;
    drive(v);
    set_id(1, 6'd20);
    #1;
    chk("pre_edge_data",  rd_data(1),  32'h0);
    chk("pre_edge_valid", rd_valid(1), 1'b1);
    @(posedge clk);
    #1;
    model_step(v);
    drive('0);
    #1;
    chk("post_edge_data",  rd_data(1),  32'hdeadbeef);
    chk("post_edge_valid", rd_valid(1), 1'b1);

    // Reset wins over simultaneous writes and restore.
    @(negedge clk);
    v = '0; v.we = '1; v.rs = 1'b1; v.img = '1;
    for (int p = 0; p < 4; p++) begin
      v.wid[p] = IDW'(p + 40); v.wdata[p] = 32'hffff0000 + p;
    end
    drive(v);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive('0);
    model_reset();
    check_all("rst_override");

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      v = '0;
      for (int p = 0; p < WBW; p++) begin
        v.we[p] = $urandom_range(0, 1) == 1;
        v.wid[p] = IDW'($urandom_range(0, N - 1));
        v.wdata[p] = $urandom;
      end
      for (int c = 0; c < CW; c++) begin
        v.cinv[c] = $urandom_range(0, 3) == 0;
        v.cid[c] = IDW'($urandom_range(0, N - 1));
      end
      v.fl  = $urandom_range(0, 4) == 0;
      v.fid = IDW'($urandom_range(0, N - 1));
      v.rs  = $urandom_range(0, 19) == 0;
      v.img = {$urandom, $urandom};
      drive(v);
      for (int k = 0; k < 8; k++) set_id(k, IDW'($urandom_range(0, N - 1)));
      #1;
      for (int k = 0; k < 8; k++) begin
        int id;
        id = (k < 4) ? int'(bus.readreg_phyf_id[k/2][k%2]) : int'(bus.issue_phyf_id[(k-4)/2][k%2]);
        chk("rand_valid", rd_valid(k), m_valid[id]);
        chk("rand_data",  rd_data(k),  m_data[id]);
      end
      @(posedge clk);
      #1;
      model_step(v);
    end
    drive('0);
    check_all("rand_final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
